multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 32-bit processor datapath: PC counter, instruction memory/IR, register file, ALU and data memory.
- Sequences each instruction through FETCH, DECODE, EXEC, optional MEM, then WB.
- Owns the imem/dmem req/ack handshakes, ALU op select, regfile read/write strobes and the PC update.
- Retires one instruction per pass.
- Opcode set:
  - 100011: load
  - 101011: store
  - 000001: R-type; funct 100000 add, 100010 sub, 100100 and, 100101 or
  - 000010: beq

Parameters:
- TIMEOUT, 16: max cycles a memory req waits for ack before ERR; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run  in  1  level; 1 = execute instructions continuously
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU result == 0
- imem_ack  in  1  instruction-fetch acknowledge
- dmem_ack  in  1  data-memory acknowledge
- imem_req  out  1  instruction-fetch request
- ir_load  out  1  IR load strobe
- rf_re  out  1  regfile operand read strobe
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- alu_src_imm  out  1  1 = ALU B operand is the sign-extended immediate
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write (store)
- rf_we  out  1  regfile write strobe
- wb_sel_mem  out  1  1 = write-back data from dmem, 0 = from ALU
- pc_en  out  1  PC update strobe
- pc_branch  out  1  with pc_en: PC += offset, else PC += 1
- busy  out  1  state not IDLE and not ERR
- err  out  1  sticky error flag
- err_code  out  2  01 fetch timeout, 10 dmem timeout, 11 illegal opcode
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (sync, highest priority, any state including mid-instruction):
  - state goes to IDLE.
  - All outputs 0, retired 0, timeout counter 0, latched class/op 0.
- State IDLE:
  - Outputs 0.
  - run=1 goes to FETCH next cycle.
- State FETCH:
  - imem_req=1 held until imem_ack.
  - On the ack cycle: ir_load=1 for that cycle only, next state DECODE.
- State DECODE, one cycle:
  - rf_re=1.
  - Samples opcode/funct and latches the instruction class and alu_op/alu_src_imm; these are held until the next DECODE.
  - load/store: ADD, imm=1.
  - R-type: op from funct, imm=0.
  - beq: SUB, imm=0.
  - Next state EXEC.
  - Unknown opcode or unknown R-type funct is illegal; handling is under Optional Feature.
- State EXEC, one cycle:
  - load/store go to MEM; R-type and beq go to WB.
  - beq: alu_zero is registered here as the taken flag.
- State MEM:
  - dmem_req=1; dmem_we=1 for store, 0 for load; both held until dmem_ack.
  - On the ack cycle, next state WB.
- State WB, one cycle:
  - pc_en=1.
  - pc_branch = taken flag for beq, else 0.
  - rf_we=1 for load and R-type; wb_sel_mem=1 for load.
  - retired increments and wraps modulo 2^CNT_W.
  - Next state FETCH if run=1, else IDLE.
- Latency with ack in the same cycle as req:
  - R-type and beq: 4 cycles.
  - load and store: 5 cycles.
  - Each cycle of ack delay adds 1.
- run deasserted mid-instruction: the instruction completes through WB, then IDLE.
- Acks arriving while the matching req is 0 are ignored.
- Timeout (TIMEOUT > 0):
  - The counter clears on entry to FETCH/MEM and counts req-high cycles.
  - An ack in the TIMEOUT-th req cycle is accepted.
  - No ack by the end of that cycle goes to ERR next cycle with code 01 (FETCH) or 10 (MEM).
- State ERR:
  - All strobes 0, err=1, err_code held.
  - Exits only by reset.

Optional Feature:
- Macro: MCTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to ERR with err_code=11; no pc_en and no retire.
- Undefined: an illegal instruction is a NOP.
  - DECODE goes directly to WB: pc_en=1, pc_branch=0, rf_we=0, retired increments.
  - Total 3 cycles with ack in the same cycle as req.

Test Plan:
- R-type add: reset, run=1, opcode=000001 funct=100000, acks same-cycle -> ir_load cycle 1, alu_op=00 imm=0, rf_we=1 and pc_en=1 in cycle 4 only, wb_sel_mem=0, retired=1.
- load then store, dmem_ack delayed 3 cycles -> dmem_req high 3 cycles with dmem_we=0 (load), then =1 (store); load WB has rf_we=1 and wb_sel_mem=1; store WB has rf_we=0; retired=2.
- beq opcode=000010: alu_zero=1 in EXEC -> WB pc_en=1 pc_branch=1; repeat with alu_zero=0 -> pc_branch=0; alu_op=01 both times.
- imem_ack never asserted, TIMEOUT=16 -> imem_req high exactly 16 cycles, then err=1, err_code=01, busy=0, strobes stay 0 until reset.
- opcode=111111, each macro setting:
  - MCTRL_ILLEGAL_TRAP_EN defined -> err_code=11, retired unchanged.
  - MCTRL_ILLEGAL_TRAP_EN undefined -> pc_en in cycle 3, retired+1.
- Reset asserted during MEM with dmem_req high -> next cycle all outputs 0, state IDLE, retired=0.
- run dropped during EXEC -> WB completes, then IDLE, busy=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the multi-cycle 32-bit datapath. Each instruction walks
// through FETCH -> DECODE -> EXEC -> [MEM] -> WB, and one instruction retires
// on each pass. This block drives the imem/dmem request/acknowledge
// handshakes, the ALU operation select, the register-file read/write strobes
// and the PC update.
//
// Parameters
//   TIMEOUT  Maximum number of request-high cycles a memory access may wait
//            for its ack before the FSM enters ERR. 0 disables the timeout.
//   CNT_W    Width of the retired-instruction counter (wraps).
//
// Build option
//   MCTRL_ILLEGAL_TRAP_EN  When defined, an illegal opcode or R-type funct
//            traps to ERR with err_code=11. When undefined, it retires as a
//            NOP (DECODE -> WB, PC += 1, no register write).
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   run                 level: 1 = keep fetching instructions
//   opcode, funct       IR[31:26] and IR[5:0]
//   alu_zero            ALU result == 0 (sampled in EXEC for beq)
//   imem_ack, dmem_ack  memory acknowledges (ignored while the req is low)
//   imem_req, ir_load   instruction fetch request / IR load strobe
//   rf_re, rf_we        register-file read / write strobes
//   alu_op, alu_src_imm ALU op (00 ADD, 01 SUB, 10 AND, 11 OR) / B = imm
//   dmem_req, dmem_we   data-memory request / write enable
//   wb_sel_mem          write-back data from dmem (1) or ALU (0)
//   pc_en, pc_branch    PC update strobe / take branch offset
//   busy, err, err_code FSM status; err_code 01 fetch timeout,
//                       10 dmem timeout, 11 illegal instruction
//   retired             count of completed instructions
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             rf_re,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             wb_sel_mem,
    output logic             pc_en,
    output logic             pc_branch,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Instruction class latched in DECODE. C_NOP doubles as the reset value
    // and as the class of an illegal instruction retired as a NOP.
    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_LOAD  = 3'd1;
    localparam logic [2:0] C_STORE = 3'd2;
    localparam logic [2:0] C_RTYPE = 3'd3;
    localparam logic [2:0] C_BEQ   = 3'd4;

    state_t           state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic [1:0]       op_q, op_d;
    logic             imm_q, imm_d;
    logic             taken_q, taken_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [2:0] dec_cls;
    logic [1:0] dec_op;
    logic       dec_imm;
    logic       dec_illegal;
    logic       tmo_last;

    // High during the TIMEOUT-th request cycle: an ack in this cycle is still
    // accepted, otherwise the access is abandoned.
    assign tmo_last = (TIMEOUT > 0) && (tmo_q == TW'(TIMEOUT - 1));

    // Instruction decode (only consumed in DECODE).
    always_comb begin
        dec_cls     = C_NOP;
        dec_op      = 2'b00;
        dec_imm     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            6'b100011: begin dec_cls = C_LOAD;  dec_op = 2'b00; dec_imm = 1'b1; end
            6'b101011: begin dec_cls = C_STORE; dec_op = 2'b00; dec_imm = 1'b1; end
            6'b000010: begin dec_cls = C_BEQ;   dec_op = 2'b01; dec_imm = 1'b0; end
            6'b000001: begin
                dec_cls = C_RTYPE;
                case (funct)
                    6'b100000: dec_op = 2'b00;
                    6'b100010: dec_op = 2'b01;
                    6'b100100: dec_op = 2'b10;
                    6'b100101: dec_op = 2'b11;
                    default: begin
                        dec_cls     = C_NOP;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // State and datapath-control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cls_q      <= C_NOP;
            op_q       <= 2'b00;
            imm_q      <= 1'b0;
            taken_q    <= 1'b0;
            tmo_q      <= '0;
            err_code_q <= 2'b00;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            taken_q    <= taken_d;
            tmo_q      <= tmo_d;
            err_code_q <= err_code_d;
            retired_q  <= retired_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        op_d       = op_q;
        imm_d      = imm_q;
        taken_d    = taken_q;
        err_code_d = err_code_q;
        retired_d  = retired_q;
        // Outside FETCH/MEM the counter sits at zero, so it starts fresh on
        // every entry to a request state.
        tmo_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                tmo_d = tmo_q + 1'b1;
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (tmo_last) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b01;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                op_d  = dec_op;
                imm_d = dec_imm;
                if (dec_illegal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    state_d    = S_ERR;
                    err_code_d = 2'b11;
`else
                    state_d    = S_WB;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = (cls_q == C_BEQ) && alu_zero;
                if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
                else                                     state_d = S_WB;
            end
            S_MEM: begin
                tmo_d = tmo_q + 1'b1;
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (tmo_last) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end
            end
            S_WB: begin
                retired_d = retired_q + 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_ERR: state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        rf_re       = 1'b0;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        wb_sel_mem  = 1'b0;
        pc_en       = 1'b0;
        pc_branch   = 1'b0;
        busy        = (state_q != S_IDLE) && (state_q != S_ERR);
        err         = (state_q == S_ERR);
        err_code    = err_code_q;
        retired     = retired_q;
        // ALU controls hold the last decoded values; IDLE shows all zeros.
        if (state_q != S_IDLE) begin
            alu_op      = op_q;
            alu_src_imm = imm_q;
        end
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_DECODE: rf_re = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
            end
            S_WB: begin
                pc_en      = 1'b1;
                pc_branch  = (cls_q == C_BEQ) && taken_q;
                rf_we      = (cls_q == C_LOAD) || (cls_q == C_RTYPE);
                wb_sel_mem = (cls_q == C_LOAD);
            end
            default: ;
        endcase
    end

endmodule
